iteration_accumulator: RTL and testbench
========================================

# iteration_accumulator

Consumer stage for the iteration counter in the single-cycle math accelerator. It clears the counter and uses the counter's byte-address output to read one data word per step from a word memory. It accumulates the signed words into a wide accumulator until the counter's overflow flag ends the run, then presents a saturated 32-bit result on a valid/ready handshake.

## Interface
- DATA_W, 32: width of memory words and result (signed two's complement)
- ACC_W, 40: accumulator width; ACC_W > DATA_W
- CNT_W, 24: width of counter value and memory address
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- cnt_clr  out  1  clear to the iteration counter; one-cycle pulse
- iter_count  in  CNT_W  counter byte address (steps of 4, registered one cycle behind the counter's internal value)
- iter_ovf  in  1  counter overflow; high once the count has passed the last address
- mem_rden  out  1  memory read enable
- mem_addr  out  CNT_W  read address, equal to iter_count when mem_rden=1, else 0
- mem_rdata  in  DATA_W  read data, valid in the cycle after mem_rden
- result  out  DATA_W  saturated sum; stable while result_valid=1
- sat  out  1  result was clipped to the DATA_W range
- n_terms  out  16  number of words accumulated in the run
- result_valid  out  1  result available
- result_ready  in  1  downstream accepts result

## Operation
- States: IDLE, CLEAR, SETTLE, RUN, DRAIN, DONE.
- IDLE:
  - busy=0. On start=1, clear acc, n_terms and rd_pend, then go to CLEAR.
- CLEAR:
  - cnt_clr=1 for exactly this cycle, then go to SETTLE.
- SETTLE:
  - iter_count is stale here and is ignored; no read is issued. Go to RUN.
- RUN, each cycle:
  - If iter_ovf=0: mem_rden=1, mem_addr=iter_count, n_terms+=1, stay in RUN.
  - If iter_ovf=1: mem_rden=0, go to DRAIN.
- Accumulate:
  - rd_pend is mem_rden delayed one cycle.
  - In any cycle with rd_pend=1, acc += sign-extended mem_rdata.
  - acc wraps modulo 2^ACC_W; with 40 bits this cannot happen for at most 256 terms.
- DRAIN:
  - The last pending word is accumulated at the edge entering DRAIN.
  - In DRAIN, register result = acc clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat=1 iff clipping occurred. Go to DONE.
- DONE:
  - result_valid=1. Hold result, sat and n_terms.
  - When result_valid && result_ready at the edge, go to IDLE.
- Ignored inputs:
  - start in any state other than IDLE is ignored; requests are not queued.
  - iter_count is ignored outside RUN.
- iter_ovf already 1 in the first RUN cycle: zero terms, result=0, sat=0, n_terms=0.
- Reset, including mid-run:
  - State returns to IDLE; acc=0, rd_pend=0.
  - Outputs: busy=0, cnt_clr=0, mem_rden=0, mem_addr=0, result=0, sat=0, n_terms=0, result_valid=0.
  - The counter shares aresetn, so no clr pulse is needed on reset.

## Timing
- Edge E0 samples start. Then: CLEAR in cycle 1, SETTLE in cycle 2, RUN from cycle 3.
- With the counter connected directly:
  - Reads issue in cycles 3..258 at addresses 0x000, 0x004, ..., 0x3FC (256 reads).
  - iter_ovf is seen in cycle 259 with iter_count=0x400.
  - DRAIN in cycle 260; result_valid rises in cycle 261.
- result_valid goes low the cycle after the accepting edge. The earliest next start is sampled in that IDLE cycle.
- No combinational path from any input to result_valid or cnt_clr.
- mem_rden and mem_addr are combinational from state and iter_ovf/iter_count. This is the only input-to-output path.

## Test plan
- mem[k]=1 for all 256 words; start; result_ready=1 -> result_valid in cycle 261, result=256, n_terms=256, sat=0; addresses 0x000..0x3FC in order, each once.
- mem[a]=a/4 -> result=32640, sat=0.
- All words 0x7FFFFFFF -> result=0x7FFFFFFF, sat=1. All words 0x80000000 -> result=0x80000000, sat=1.
- Backpressure: hold result_ready=0 for 10 cycles in DONE and pulse start twice -> result, sat and n_terms unchanged, no cnt_clr, no reads. Release -> IDLE next cycle, then a fresh start runs normally.
- aresetn=1 for one cycle during RUN at the 100th read -> all outputs at reset values the next cycle. The following start gives a full 256-term result with no residue from the aborted run.
- Hold iter_ovf=1 from the start of the run -> no mem_rden, result=0, n_terms=0, result_valid in cycle 5.

Source files
------------

// File: rtl/iteration_accumulator.sv
// Drives the iteration counter, reads one signed word per counter step and accumulates it,
// then presents the saturated sum and term count on a valid/ready handshake.
module iteration_accumulator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 24
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    output logic              busy,
    output logic              cnt_clr,
    input  logic [CNT_W-1:0]  iter_count,
    input  logic              iter_ovf,
    output logic              mem_rden,
    output logic [CNT_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] result,
    output logic              sat,
    output logic [15:0]       n_terms,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ACC_W-1:0]    r_acc;
    logic                r_rd_pend;
    logic [15:0]         r_n_terms;
    logic [DATA_W-1:0]   r_result;
    logic                r_sat;

    logic [ACC_W-1:0]    w_rdata_ext;
    logic                w_out_of_range;
    logic [DATA_W-1:0]   w_clipped;

    assign w_rdata_ext = {{(ACC_W - DATA_W){mem_rdata[DATA_W-1]}}, mem_rdata};

    // The sum fits DATA_W only when every bit from the DATA_W sign bit upward agrees.
    assign w_out_of_range = !(&r_acc[ACC_W-1:DATA_W-1]) && (|r_acc[ACC_W-1:DATA_W-1]);

    always_comb begin
        w_clipped = r_acc[DATA_W-1:0];
        if (w_out_of_range) begin
            w_clipped = r_acc[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                       : {1'b0, {(DATA_W - 1){1'b1}}};
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != StIdle);
        cnt_clr      = 1'b0;
        mem_rden     = 1'b0;
        mem_addr     = '0;
        result_valid = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) w_state_next = StClear;
            end
            StClear: begin
                cnt_clr      = 1'b1;
                w_state_next = StSettle;
            end
            // Counter output still reflects the pre-clear value here.
            StSettle: w_state_next = StRun;
            StRun: begin
                if (iter_ovf) begin
                    w_state_next = StDrain;
                end else begin
                    mem_rden = 1'b1;
                    mem_addr = iter_count;
                end
            end
            StDrain: w_state_next = StDone;
            StDone: begin
                result_valid = 1'b1;
                if (result_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_rd_pend <= 1'b0;
            r_n_terms <= '0;
            r_result  <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rd_pend <= mem_rden;
            if (r_state == StIdle && start) begin
                r_acc     <= '0;
                r_n_terms <= '0;
            end else begin
                if (r_rd_pend) r_acc <= r_acc + w_rdata_ext;
                if (mem_rden) r_n_terms <= r_n_terms + 16'd1;
            end
            if (r_state == StDrain) begin
                r_result <= w_clipped;
                r_sat    <= w_out_of_range;
            end
        end
    end

    assign result  = r_result;
    assign sat     = r_sat;
    assign n_terms = r_n_terms;

endmodule

// File: tb/tb_iteration_accumulator.sv
// Scoreboard bench: a counter and word-memory model feed the DUT, runs are predicted by summing
// the memory image, and a monitor checks addresses and each presented result.
module tb_iteration_accumulator;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = 24;
    localparam int NW     = 256;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic              start = 1'b0;
    logic              result_ready = 1'b1;
    logic              busy, cnt_clr, iter_ovf, mem_rden, sat, result_valid;
    logic [CNT_W-1:0]  iter_count, mem_addr;
    logic [DATA_W-1:0] mem_rdata, result;
    logic [15:0]       n_terms;

    iteration_accumulator #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .busy        (busy),
        .cnt_clr     (cnt_clr),
        .iter_count  (iter_count),
        .iter_ovf    (iter_ovf),
        .mem_rden    (mem_rden),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .result      (result),
        .sat         (sat),
        .n_terms     (n_terms),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 aclk = ~aclk;

    // Iteration counter: byte address advances by 4 per cycle, outputs lag internal value by one.
    logic [CNT_W-1:0] cnt_int = '0;
    logic             force_ovf = 1'b0;
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            cnt_int    <= '0;
            iter_count <= '0;
            iter_ovf   <= 1'b0;
        end else begin
            if (cnt_clr) cnt_int <= '0;
            else if (cnt_int < 24'h800) cnt_int <= cnt_int + 24'd4;
            iter_count <= cnt_int;
            iter_ovf   <= force_ovf || (cnt_int >= 24'h400);
        end
    end

    logic [DATA_W-1:0] mem [NW];
    always_ff @(posedge aclk) begin
        if (mem_rden) mem_rdata <= mem[mem_addr[9:2]];
    end

    int cyc = 0;
    always_ff @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        sat;
        logic [15:0] n;
        int          lat;
    } sb_t;

    sb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  start_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain signed sum of the memory image, clipped to 32 bits.
    task automatic push_expected(input bit ovf_run, output sb_t e);
        longint s = 0;
        if (!ovf_run) for (int i = 0; i < NW; i++) s += longint'($signed(mem[i]));
        e.n   = ovf_run ? 16'd0 : 16'(NW);
        e.lat = ovf_run ? 5 : 261;
        e.sat = 1'b0;
        if (s > 64'sd2147483647) begin
            e.res = 32'h7FFF_FFFF;
            e.sat = 1'b1;
        end else if (s < -64'sd2147483648) begin
            e.res = 32'h8000_0000;
            e.sat = 1'b1;
        end else begin
            e.res = 32'(s);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: address order per run, and each rising result_valid against the scoreboard.
    int  rd_idx = 0;
    logic prev_valid = 1'b0;
    sb_t me;
    initial forever begin
        @(negedge aclk);
        if (cnt_clr) rd_idx = 0;
        if (mem_rden) begin
            chk("read_addr", 64'(mem_addr), 64'(rd_idx * 4));
            rd_idx++;
        end
        if (result_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(result_valid), 64'd0);
            end else begin
                me = exp_q.pop_front();
                chk("result", 64'(result), 64'(me.res));
                chk("sat", 64'(sat), 64'(me.sat));
                chk("n_terms", 64'(n_terms), 64'(me.n));
                chk("valid_cycle", 64'(cyc - start_cyc + 1), 64'(me.lat));
                chk("read_count", 64'(rd_idx), 64'(me.n));
            end
        end
        prev_valid = result_valid;
    end

    task automatic pulse_start;
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !result_valid; i++) @(negedge aclk);
        chk("valid_seen", 64'(result_valid), 64'd1);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt_clr", 64'(cnt_clr), 64'd0);
        chk("rst_mem_rden", 64'(mem_rden), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        chk("rst_n_terms", 64'(n_terms), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
    endtask

    task automatic run(input bit ovf_run);
        sb_t e;
        force_ovf = ovf_run;
        push_expected(ovf_run, e);
        pulse_start();
        wait_valid(400);
        @(negedge aclk);
        chk("valid_drop", 64'(result_valid), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
        force_ovf = 1'b0;
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < NW; i++) mem[i] = v;
    endtask

    task automatic fill_rand_small;
        int v;
        for (int i = 0; i < NW; i++) begin
            v = int'($urandom_range(0, 2000000)) - 1000000;
            mem[i] = v;
        end
    endtask

    initial begin
        sb_t e;
        fill_const(32'd0);
        repeat (3) @(negedge aclk);
        chk_reset_outputs();
        aresetn = 1'b0;

        fill_const(32'd1);
        run(1'b0);

        for (int i = 0; i < NW; i++) mem[i] = i;
        run(1'b0);

        fill_const(32'h7FFF_FFFF);
        run(1'b0);
        fill_const(32'h8000_0000);
        run(1'b0);

        // Partial sums leave the 32-bit range but the total returns to zero.
        for (int i = 0; i < NW; i++) mem[i] = (i < NW / 2) ? 32'h7FFF_FFFF : 32'h8000_0001;
        run(1'b0);

        fill_rand_small();
        run(1'b0);
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        run(1'b0);

        // Backpressure in DONE with ignored start pulses.
        fill_rand_small();
        push_expected(1'b0, e);
        result_ready = 1'b0;
        pulse_start();
        wait_valid(400);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(result_valid), 64'd1);
            chk("bp_result", 64'(result), 64'(e.res));
            chk("bp_sat", 64'(sat), 64'(e.sat));
            chk("bp_n_terms", 64'(n_terms), 64'(e.n));
            chk("bp_cnt_clr", 64'(cnt_clr), 64'd0);
            chk("bp_mem_rden", 64'(mem_rden), 64'd0);
            start = (i == 2 || i == 6);
            @(negedge aclk);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release_valid", 64'(result_valid), 64'd0);
        chk("bp_release_idle", 64'(busy), 64'd0);
        fill_rand_small();
        run(1'b0);

        // Reset pulse at the 100th read of a run.
        fill_const(32'h0100_0000);
        push_expected(1'b0, e);
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (mem_rden && mem_addr == 24'd396) break;
            @(negedge aclk);
        end
        chk("abort_point", 64'(mem_addr), 64'd396);
        aresetn = 1'b1;
        @(negedge aclk);
        aresetn = 1'b0;
        chk_reset_outputs();
        exp_q.delete();
        fill_rand_small();
        run(1'b0);

        // Overflow already asserted when RUN begins.
        fill_const(32'd7);
        run(1'b1);

        fill_rand_small();
        run(1'b0);

        repeat (2) @(negedge aclk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
